// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the multi-cycle control unit and the
// instruction/data memories.
interface multicycle_control_unit_if;
   logic imem_req;
   logic imem_ready;
   logic mem_read;
   logic mem_write;
   logic dmem_ready;

   modport master (
      output imem_req,
      output mem_read,
      output mem_write,
      input  imem_ready,
      input  dmem_ready
   );

   modport slave (
      input  imem_req,
      input  mem_read,
      input  mem_write,
      output imem_ready,
      output dmem_ready
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Five-state multi-cycle control FSM for the 16-bit RISC core: per-state datapath
// controls, stalling memory handshakes, illegal-opcode and memory-timeout pulses.
module multicycle_control_unit #(
   parameter int OPCODE_W    = 4,
   parameter int ALU_OP_W    = 3,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [OPCODE_W-1:0]     opcode,
   input  logic                    alu_zero,
   multicycle_control_unit_if.master mem,
   output logic                    ir_write,
   output logic                    pc_write,
   output logic [1:0]              pc_src,
   output logic [ALU_OP_W-1:0]     alu_op,
   output logic                    alu_src,
   output logic                    reg_dst,
   output logic                    mem_to_reg,
   output logic                    reg_write,
   output logic                    illegal_op,
   output logic                    timeout,
   output logic                    instr_done,
   output logic [2:0]              state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_q, state_n;
   logic [3:0]       op_q;
   logic [CNT_W-1:0] cnt_q;

   logic imem_req_c, mem_read_c, mem_write_c;
   logic waiting, limit_hit;

   // Live-opcode decode, used only in DECODE before the opcode is latched
   logic       op_upper;
   logic [3:0] op_lo;
   logic       d_jmp, d_illegal;

   assign op_upper  = (opcode >> 4) != '0;
   assign op_lo     = opcode[3:0];
   assign d_jmp     = !op_upper && (op_lo == 4'b1101);
   assign d_illegal = op_upper || (op_lo == 4'b1010) || (op_lo == 4'b1110) ||
                      (op_lo == 4'b1111);

   logic q_lw, q_sw, q_alu, q_beq, q_bne;
   assign q_lw  = (op_q == 4'b0000);
   assign q_sw  = (op_q == 4'b0001);
   assign q_alu = (op_q >= 4'd2) && (op_q <= 4'd9);
   assign q_beq = (op_q == 4'b1011);
   assign q_bne = (op_q == 4'b1100);

   assign waiting = !reset &&
                    (((state_q == FETCH) && !mem.imem_ready) ||
                     ((state_q == MEM) && !mem.dmem_ready));
   // A ready in the limit cycle clears waiting, so ready always beats the timeout
   assign limit_hit = (MEM_TIMEOUT != 0) && waiting && (cnt_q >= CNT_LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         if (state_q == DECODE) op_q <= op_lo;
         if (waiting && !limit_hit)
            cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
         else
            cnt_q <= '0;
      end
   end

   always_comb begin
      state_n     = state_q;
      imem_req_c  = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      alu_op      = '0;
      alu_src     = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      illegal_op  = 1'b0;
      timeout     = 1'b0;
      instr_done  = 1'b0;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               imem_req_c = 1'b1;
               if (mem.imem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_n  = DECODE;
               end else if (limit_hit) begin
                  timeout = 1'b1;
                  state_n = FETCH;
               end
            end
            DECODE: begin
               if (d_illegal) begin
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
                  state_n    = FETCH;
               end else if (d_jmp) begin
                  pc_write   = 1'b1;
                  pc_src     = 2'b10;
                  instr_done = 1'b1;
                  state_n    = FETCH;
               end else begin
                  state_n = EXEC;
               end
            end
            EXEC: begin
               if (q_lw || q_sw) begin
                  alu_src = 1'b1;
                  state_n = MEM;
               end else if (q_alu) begin
                  alu_op  = ALU_OP_W'(3'(op_q - 4'd2));
                  state_n = WB;
               end else begin
                  alu_op     = ALU_OP_W'(3'b001);
                  pc_src     = 2'b01;
                  pc_write   = (q_beq && alu_zero) || (q_bne && !alu_zero);
                  instr_done = 1'b1;
                  state_n    = FETCH;
               end
            end
            MEM: begin
               alu_src     = 1'b1;
               mem_read_c  = q_lw;
               mem_write_c = q_sw;
               if (mem.dmem_ready) begin
                  if (q_lw) begin
                     state_n = WB;
                  end else begin
                     instr_done = 1'b1;
                     state_n    = FETCH;
                  end
               end else if (limit_hit) begin
                  timeout = 1'b1;
                  state_n = FETCH;
               end
            end
            WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               mem_to_reg = q_lw;
               reg_dst    = !q_lw;
               state_n    = FETCH;
            end
            default: state_n = FETCH;
         endcase
      end
   end

   assign mem.imem_req  = imem_req_c;
   assign mem.mem_read  = mem_read_c;
   assign mem.mem_write = mem_write_c;
   assign state         = reset ? 3'd0 : 3'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each issued instruction pushes its expected per-instruction
// summary; a monitor accumulates DUT activity and checks it at completion.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] opcode = 4'b0010;
   logic       alu_zero = 1'b0;

   logic       ir_write, pc_write, alu_src, reg_dst, mem_to_reg, reg_write;
   logic       illegal_op, tmo, instr_done;
   logic [1:0] pc_src;
   logic [2:0] alu_op, state;

   multicycle_control_unit_if mif ();

   multicycle_control_unit #(
      .OPCODE_W(4),
      .ALU_OP_W(3),
      .MEM_TIMEOUT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .opcode(opcode),
      .alu_zero(alu_zero),
      .mem(mif),
      .ir_write(ir_write),
      .pc_write(pc_write),
      .pc_src(pc_src),
      .alu_op(alu_op),
      .alu_src(alu_src),
      .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg),
      .reg_write(reg_write),
      .illegal_op(illegal_op),
      .timeout(tmo),
      .instr_done(instr_done),
      .state(state)
   );

   always #5 clk = ~clk;

   // Memory responders: ready after a programmable number of stalled request cycles
   int istall = 0, dstall = 0, icnt = 0, dcnt = 0;
   assign mif.imem_ready = mif.imem_req && (icnt == istall);
   assign mif.dmem_ready = (mif.mem_read || mif.mem_write) && (dcnt == dstall);
   always @(posedge clk) begin
      icnt <= (mif.imem_req && !mif.imem_ready && !tmo) ? icnt + 1 : 0;
      dcnt <= ((mif.mem_read || mif.mem_write) && !mif.dmem_ready && !tmo) ? dcnt + 1 : 0;
   end

   typedef struct {
      string name;
      int cycles; int pcw; int rw; int mr; int mw;
      int done; int ill; int to; int alu; int pcsrc; int m2r; int rdst;
   } exp_t;

   exp_t q[$];
   exp_t acc;
   int   vectors = 0, miscompares = 0, completed = 0;

   function automatic exp_t mk(string n, int cyc, int pcw, int rw, int mr, int mw,
                               int done, int ill, int to, int alu, int pcsrc,
                               int m2r, int rdst);
      exp_t e;
      e.name = n; e.cycles = cyc; e.pcw = pcw; e.rw = rw; e.mr = mr; e.mw = mw;
      e.done = done; e.ill = ill; e.to = to; e.alu = alu; e.pcsrc = pcsrc;
      e.m2r = m2r; e.rdst = rdst;
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic void clear_acc();
      acc = mk("", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   initial clear_acc();

   always @(negedge clk) begin
      if (reset) begin
         clear_acc();
      end else begin
         acc.cycles++;
         if (pc_write) begin
            acc.pcw++;
            acc.pcsrc = int'(pc_src);
         end
         if (reg_write) acc.rw++;
         if (mif.mem_read) acc.mr++;
         if (mif.mem_write) acc.mw++;
         if (illegal_op) acc.ill++;
         if (state == 3'd2) acc.alu = int'(alu_op);
         if (state == 3'd4) begin
            acc.m2r  = int'(mem_to_reg);
            acc.rdst = int'(reg_dst);
         end
         if (instr_done || tmo) begin
            acc.done = int'(instr_done);
            acc.to   = int'(tmo);
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_completion: got done=%0b timeout=%0b expected none",
                        instr_done, tmo);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk({e.name, ".cycles"}, acc.cycles, e.cycles);
               chk({e.name, ".pc_write_cycles"}, acc.pcw, e.pcw);
               chk({e.name, ".reg_write_cycles"}, acc.rw, e.rw);
               chk({e.name, ".mem_read_cycles"}, acc.mr, e.mr);
               chk({e.name, ".mem_write_cycles"}, acc.mw, e.mw);
               chk({e.name, ".instr_done"}, acc.done, e.done);
               chk({e.name, ".illegal_op"}, acc.ill, e.ill);
               chk({e.name, ".timeout"}, acc.to, e.to);
               chk({e.name, ".exec_alu_op"}, acc.alu, e.alu);
               chk({e.name, ".last_pc_src"}, acc.pcsrc, e.pcsrc);
               chk({e.name, ".wb_mem_to_reg"}, acc.m2r, e.m2r);
               chk({e.name, ".wb_reg_dst"}, acc.rdst, e.rdst);
            end
            clear_acc();
            completed++;
         end
      end
   end

   function automatic logic [31:0] all_outs();
      return 32'({mif.imem_req, ir_write, pc_write, pc_src, alu_op, alu_src, reg_dst,
                  mem_to_reg, reg_write, mif.mem_read, mif.mem_write, illegal_op, tmo,
                  instr_done, state});
   endfunction

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   task automatic wait_done();
      int target;
      target = completed + 1;
      for (int n = 0; n < 100 && completed < target; n++) @(posedge clk);
      if (completed < target) begin
         vectors++;
         miscompares++;
         $display("FAIL completion_wait: got %0d completions expected %0d", completed, target);
         finish_run();
      end
      #1;
   endtask

   task automatic issue(logic [3:0] op, logic z, int ist, int dst, exp_t e);
      opcode   = op;
      alu_zero = z;
      istall   = ist;
      dstall   = dst;
      q.push_back(e);
      wait_done();
   endtask

   initial begin
      int saved;
      istall = 0;
      dstall = 0;
      opcode = 4'b0010;
      q.push_back(mk("add", 4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs_zero", all_outs(), 0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_reset_state", 32'(state), 0);
      chk("post_reset_imem_req", 32'(mif.imem_req), 1);
      wait_done();

      issue(4'b0000, 1'b0, 0, 3,    mk("lw_dstall3",        8, 1, 1, 4, 0, 1, 0, 0, 0, 0, 1, 0));
      issue(4'b1011, 1'b1, 0, 0,    mk("beq_z1",            3, 2, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
      issue(4'b1100, 1'b1, 0, 0,    mk("bne_z1",            3, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
      issue(4'b1110, 1'b0, 0, 0,    mk("illegal_1110",      2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      issue(4'b1101, 1'b0, 0, 0,    mk("jmp",               2, 2, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0));
      issue(4'b0001, 1'b0, 0, 3,    mk("sw_ready_at_limit", 7, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0));
      issue(4'b0010, 1'b0, 1000, 0, mk("fetch_timeout",     4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      issue(4'b0011, 1'b0, 2, 0,    mk("sub_istall2",       6, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1));
      issue(4'b0001, 1'b0, 0, 1000, mk("sw_mem_timeout",    7, 1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0));
      issue(4'b1001, 1'b0, 0, 0,    mk("slt",               4, 1, 1, 0, 0, 1, 0, 0, 7, 0, 0, 1));
      issue(4'b1011, 1'b0, 0, 0,    mk("beq_z0",            3, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
      issue(4'b1010, 1'b0, 0, 0,    mk("illegal_1010",      2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      issue(4'b0000, 1'b0, 0, 0,    mk("lw",                5, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0));
      issue(4'b1100, 1'b0, 0, 0,    mk("bne_z0",            3, 2, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
      issue(4'b0010, 1'b0, 3, 0,    mk("add_istall3",       7, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
      issue(4'b0110, 1'b0, 0, 0,    mk("and_op",            4, 1, 1, 0, 0, 1, 0, 0, 4, 0, 0, 1));

      // Abort a stalled SW in MEM with reset; nothing may complete
      saved    = completed;
      opcode   = 4'b0001;
      dstall   = 1000;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("mid_reset_outputs_zero", all_outs(), 0);
      opcode = 4'b0010;
      istall = 0;
      dstall = 0;
      q.push_back(mk("add_after_abort", 4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_no_completion", completed, saved);
      chk("abort_state", 32'(state), 0);
      chk("abort_imem_req", 32'(mif.imem_req), 1);
      wait_done();

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", q.size(), 0);
      finish_run();
   end

   initial begin
      #100000;
      $display("FAIL global_watchdog: got no end of run expected finish before 100000");
      $fatal(1, "watchdog");
   end

endmodule
